// File: rtl/ws2812_frame_driver.sv
// WS2812 strip driver: on each start it reads one colour per LED from a 1-cycle-latency ROM,
// blanks LEDs at or above the requested level, and streams GRB bits followed by a latch gap.
module ws2812_frame_driver #(
    parameter int N_LEDS = 16,
    parameter int T_BIT  = 63,
    parameter int T0H    = 20,
    parameter int T1H    = 40,
    parameter int T_RES  = 3000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_level,
    output logic        o_busy,
    output logic [7:0]  o_rom_addr,
    output logic        o_rom_ren,
    input  logic [23:0] i_rom_data,
    output logic        o_dout,
    output logic        o_done
);

    localparam int CNT_MAX = (T_RES > T_BIT) ? T_RES : T_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(T_BIT - 1);
    localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(T_RES - 1);
    localparam logic [CNT_W-1:0] HI0       = CNT_W'(T0H);
    localparam logic [CNT_W-1:0] HI1       = CNT_W'(T1H);
    localparam logic [7:0]       LED_LAST  = 8'(N_LEDS - 1);
    localparam logic [8:0]       LEVEL_MAX = 9'(N_LEDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_LATCH
    } state_t;

    state_t           state_q;
    logic [7:0]       led_q;
    logic [8:0]       level_q;
    logic [23:0]      shift_q;
    logic [4:0]       bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             ren_q;
    logic             dout_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hi_len;

    // The shared timer counts bit phases in SEND and the latch gap in LATCH.
    assign cnt_d  = cnt_q + CNT_W'(1);
    assign hi_len = shift_q[23] ? HI1 : HI0;

    // NOTE: every register, datapath included, sits in the synchronous reset so an aborted
    // frame leaves no stale colour, index or timer behind for the next start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            led_q   <= '0;
            level_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ren_q   <= 1'b0;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // done_q is still high on the return cycle, so a start coinciding with it is dropped.
                    if (i_start && !done_q) begin
                        level_q <= ({1'b0, i_level} > LEVEL_MAX) ? LEVEL_MAX : {1'b0, i_level};
                        led_q   <= '0;
                        ren_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ren_q   <= 1'b0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q <= ({1'b0, led_q} < level_q)
                             ? {i_rom_data[15:8], i_rom_data[23:16], i_rom_data[7:0]}
                             : 24'h000000;
                    bit_q   <= 5'd23;
                    cnt_q   <= '0;
                    dout_q  <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 5'd0) begin
                            dout_q <= 1'b0;
                            if (led_q == LED_LAST) begin
                                state_q <= S_LATCH;
                            end else begin
                                led_q   <= led_q + 8'd1;
                                ren_q   <= 1'b1;
                                state_q <= S_FETCH;
                            end
                        end else begin
                            bit_q   <= bit_q - 5'd1;
                            shift_q <= {shift_q[22:0], 1'b0};
                            dout_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q  <= cnt_d;
                        dout_q <= (cnt_d < hi_len);
                    end
                end
                S_LATCH: begin
                    if (cnt_q == RES_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_rom_addr = led_q;
    assign o_rom_ren  = ren_q;
    assign o_dout     = dout_q;
    assign o_done     = done_q;

endmodule
